// File: rtl/vmul_issue_ctrl.sv
// vmul_issue_ctrl: issue/sequence controller for the vector multiplier.
// Accepts one request at a time (in_valid/in_ready) and registers its operands,
// control and per-chunk sign signals. It holds mul_* stable for MUL_LATENCY edges,
// captures mul_result and presents it with backpressure (out_valid/out_ready).
module vmul_issue_ctrl #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_opcode,
  input  logic [1:0]       in_precision,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic [1:0]       mul_opcode,
  output logic [1:0]       mul_precision,
  output logic [3:0]       mul_sign_a,
  output logic [3:0]       mul_sign_b,
  input  logic [31:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [31:0]      a_q, b_q, data_q;
  logic [1:0]       op_q, prec_q;
  logic [3:0]       sign_a_q, sign_b_q;
  logic [TAG_W-1:0] req_tag_q, tag_q;

  logic       accept;
  logic [1:0] prec_d;
  logic [3:0] sign_a_d, sign_b_d;

  // Sign of the lane that owns each byte position.
  function automatic logic [3:0] lane_signs(input logic [31:0] x, input logic [1:0] prec,
                                            input logic is_signed);
    logic [3:0] s;
    case (prec)
      2'b01:   s = {{2{x[31]}}, {2{x[15]}}};
      2'b10:   s = {4{x[31]}};
      default: s = {x[31], x[23], x[15], x[7]};
    endcase
    return is_signed ? s : '0;
  endfunction

  always_comb begin
    prec_d   = (in_precision == 2'b11) ? 2'b00 : in_precision;
    sign_a_d = lane_signs(in_a, prec_d, in_opcode != 2'b10);
    sign_b_d = lane_signs(in_b, prec_d, in_opcode[1] == 1'b0);
  end

  assign in_ready = !rst && (state_q == IDLE || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      prec_q    <= '0;
      sign_a_q  <= '0;
      sign_b_q  <= '0;
      req_tag_q <= '0;
      data_q    <= '0;
      tag_q     <= '0;
    end else begin
      // Load happens from IDLE and from HOLD (release and accept on one edge).
      if (accept) begin
        a_q       <= in_a;
        b_q       <= in_b;
        op_q      <= in_opcode;
        prec_q    <= prec_d;
        sign_a_q  <= sign_a_d;
        sign_b_q  <= sign_b_d;
        req_tag_q <= in_tag;
        cnt_q     <= CNT_LOAD;
      end
      case (state_q)
        IDLE: if (in_valid) state_q <= BUSY;
        BUSY: begin
          if (cnt_q == 4'd0) begin
            data_q  <= mul_result;
            tag_q   <= req_tag_q;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: if (out_ready) state_q <= in_valid ? BUSY : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_a         = a_q;
  assign mul_b         = b_q;
  assign mul_opcode    = op_q;
  assign mul_precision = prec_q;
  assign mul_sign_a    = sign_a_q;
  assign mul_sign_b    = sign_b_q;
  assign out_valid     = (state_q == HOLD);
  assign busy          = (state_q != IDLE);
  assign out_data      = data_q;
  assign out_tag       = tag_q;

endmodule

// File: tb/tb_vmul_issue_ctrl.sv
module tb_vmul_issue_ctrl;
  localparam int unsigned LAT = 2;
  localparam int unsigned TW  = 5;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]   in_a, in_b, mul_a, mul_b, mul_result, out_data;
  logic [1:0]    in_opcode, in_precision, mul_opcode, mul_precision;
  logic [3:0]    mul_sign_a, mul_sign_b;
  logic [TW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  vmul_issue_ctrl #(.MUL_LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode), .in_precision(in_precision),
    .in_tag(in_tag), .mul_a(mul_a), .mul_b(mul_b), .mul_opcode(mul_opcode),
    .mul_precision(mul_precision), .mul_sign_a(mul_sign_a), .mul_sign_b(mul_sign_b),
    .mul_result(mul_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lane_w(input logic [1:0] prec);
    return (prec == 2'b01) ? 16 : (prec == 2'b10) ? 32 : 8;
  endfunction

  // Behavioural lane-wise multiplier: MUL keeps the low half, others the high half.
  function automatic logic [31:0] dp(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] op, input logic [1:0] prec);
    int unsigned w;
    logic [63:0] mask, ua, ub, p, lane;
    logic [31:0] r;
    w = lane_w(prec);
    mask = (64'd1 << w) - 64'd1;
    r = '0;
    for (int unsigned l = 0; l < 32 / w; l++) begin
      ua = (64'(a) >> (l * w)) & mask;
      ub = (64'(b) >> (l * w)) & mask;
      if (op != 2'b10 && ua[w-1]) ua = ua | ~mask;
      if (op[1] == 1'b0 && ub[w-1]) ub = ub | ~mask;
      p = ua * ub;
      lane = ((op == 2'b00) ? p : (p >> w)) & mask;
      r = r | 32'(lane << (l * w));
    end
    return r;
  endfunction

  // Each byte position takes the MSB of the lane that contains it.
  function automatic logic [3:0] exp_signs(input logic [31:0] x, input logic [1:0] prec,
                                           input logic is_signed);
    int unsigned w;
    logic [3:0] s;
    w = lane_w(prec);
    for (int unsigned i = 0; i < 4; i++) s[i] = is_signed & x[((i * 8) / w) * w + w - 1];
    return s;
  endfunction

  // Datapath model: result of the operands is valid LAT edges after launch.
  logic [31:0] dp_now;
  logic [31:0] dp_pipe [1:15];
  assign dp_now = dp(mul_a, mul_b, mul_opcode, mul_precision);
  always @(posedge clk) begin
    dp_pipe[1] <= dp_now;
    for (int i = 2; i <= 15; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign mul_result = (LAT == 1) ? dp_now : dp_pipe[(LAT > 1) ? LAT - 1 : 1];

  // Reference model: one request in flight, result appears LAT edges after acceptance.
  bit          m_live = 1'b0, m_inflight, m_valid, m_acc;
  int          m_left;
  logic [31:0] m_a, m_b, m_data;
  logic [1:0]  m_op, m_prec;
  logic [3:0]  m_sa, m_sb;
  logic [TW-1:0] m_tag, m_ptag;

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1; m_inflight = 1'b0; m_valid = 1'b0; m_left = 0;
      m_a = '0; m_b = '0; m_op = '0; m_prec = '0; m_sa = '0; m_sb = '0;
      m_data = '0; m_tag = '0; m_ptag = '0;
    end else if (m_live) begin
      m_acc = in_valid && !m_inflight && (!m_valid || out_ready);
      if (m_inflight) begin
        m_left--;
        if (m_left == 0) begin
          m_inflight = 1'b0;
          m_valid    = 1'b1;
          m_data     = dp(m_a, m_b, m_op, m_prec);
          m_tag      = m_ptag;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (m_acc) begin
        m_a = in_a; m_b = in_b; m_op = in_opcode;
        m_prec = (in_precision == 2'b11) ? 2'b00 : in_precision;
        m_sa = exp_signs(in_a, m_prec, in_opcode != 2'b10);
        m_sb = exp_signs(in_b, m_prec, in_opcode < 2'd2);
        m_ptag = in_tag;
        m_inflight = 1'b1;
        m_left = LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", in_ready, !rst && !m_inflight && (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      check("busy", busy, m_inflight || m_valid);
      check("out_data", out_data, m_data);
      check("out_tag", out_tag, m_tag);
      check("mul_a", mul_a, m_a);
      check("mul_b", mul_b, m_b);
      check("mul_opcode", mul_opcode, m_op);
      check("mul_precision", mul_precision, m_prec);
      check("mul_sign_a", mul_sign_a, m_sa);
      check("mul_sign_b", mul_sign_b, m_sb);
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [1:0] prec, input logic [TW-1:0] tag);
    int unsigned k;
    in_a = a; in_b = b; in_opcode = op; in_precision = prec; in_tag = tag;
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid is seen; returns at that negedge.
  task automatic wait_valid(output int unsigned k);
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (k > 50) check("valid_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int unsigned k;
    wait_valid(k);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [31:0] d;
    logic [TW-1:0] t;
    logic rdy_s;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_opcode = '0; in_precision = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Basic latency and result (first negedge is half a cycle after acceptance).
    send(32'hFFFF_FFFE, 32'h0000_0003, 2'b00, 2'b10, 5'd5);
    wait_valid(k);
    check("t1_latency", k, LAT + 1);
    check("t1_data", out_data, 32'hFFFF_FFFA);
    check("t1_tag", out_tag, 5'd5);
    @(posedge clk); #1;

    send(32'h807F_FF01, 32'h0101_0101, 2'b01, 2'b00, 5'd1);
    check("s8_sa", mul_sign_a, 4'b1010);
    check("s8_sb", mul_sign_b, 4'b0000);
    drain();
    send(32'h807F_FF01, 32'h0101_0101, 2'b10, 2'b00, 5'd2);
    check("s8u_sa", mul_sign_a, 4'b0000);
    check("s8u_sb", mul_sign_b, 4'b0000);
    drain();
    send(32'h8000_7FFF, 32'hFFFF_FFFF, 2'b11, 2'b01, 5'd3);
    check("s16_sa", mul_sign_a, 4'b1100);
    check("s16_sb", mul_sign_b, 4'b0000);
    drain();
    send(32'h8000_0000, 32'h0000_0001, 2'b00, 2'b10, 5'd4);
    check("s32_sa", mul_sign_a, 4'b1111);
    drain();
    send(32'h807F_FF01, 32'h0101_0101, 2'b01, 2'b11, 5'd6);
    check("p11_prec", mul_precision, 2'b00);
    check("p11_sa", mul_sign_a, 4'b1010);
    drain();

    // Backpressure, then release and accept on the same edge.
    out_ready = 1'b0;
    send(32'h0000_0007, 32'h0000_0006, 2'b00, 2'b10, 5'd9);
    wait_valid(k);
    d = out_data; t = out_tag;
    check("bp_data", d, 32'h0000_002A);
    check("bp_tag", t, 5'd9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, d);
      check("bp_hold_tag", out_tag, t);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    in_a = 32'h1234_5678; in_b = 32'h0000_0002; in_opcode = 2'b00;
    in_precision = 2'b10; in_tag = 5'd10; in_valid = 1'b1;
    @(negedge clk);
    check("bp_pending_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("chain_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("chain_valid", out_valid, 1'b0);
    check("chain_busy", busy, 1'b1);
    check("chain_mul_a", mul_a, 32'h1234_5678);
    wait_valid(k);
    check("chain_data", out_data, 32'h2468_ACF0);
    check("chain_tag", out_tag, 5'd10);
    @(posedge clk); #1;

    // Reset while BUSY with the counter at 1.
    send(32'h8080_8080, 32'h8080_8080, 2'b01, 2'b00, 5'h1F);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mr_valid", out_valid, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_data", out_data, 32'h0);
    check("mr_tag", out_tag, 5'h0);
    check("mr_mul_a", mul_a, 32'h0);
    check("mr_mul_b", mul_b, 32'h0);
    check("mr_ctrl", {mul_opcode, mul_precision}, 4'h0);
    check("mr_signs", {mul_sign_a, mul_sign_b}, 8'h00);
    @(negedge clk);
    check("mr_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mr_no_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Randomized traffic with backpressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rdy_s = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy_s) in_valid = 1'b0;
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_a = $urandom; in_b = $urandom;
        in_opcode = 2'($urandom_range(0, 3));
        in_precision = 2'($urandom_range(0, 3));
        in_tag = TW'($urandom);
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
